apb_master_bridge: RTL and testbench
====================================

# apb_master_bridge

Single-outstanding APB initiator that drives the `APB_BUS.Master` modport from a simple valid/ready request channel. It connects a core or DMA-side port to the SoC peripheral APB bus in front of the address decoder. It sequences SETUP/ACCESS phases and waits on `pready`. It returns read data and error status on a response channel, and a programmable watchdog aborts hung transfers.

## Interface
- `APB_ADDR_WIDTH`, 32: address width; must match the connected `APB_BUS`.
- `APB_DATA_WIDTH`, 32: data width; must match the connected `APB_BUS`.
- `TIMEOUT_CYCLES`, 256: maximum ACCESS-phase cycles before abort; 0 disables the watchdog.
- `clk`, in, 1: clock. One clock domain.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req_valid_i`, in, 1: request present.
- `req_ready_o`, out, 1: request accepted when high together with `req_valid_i`.
- `req_addr_i`, in, APB_ADDR_WIDTH: transfer address.
- `req_we_i`, in, 1: 1 = write, 0 = read.
- `req_wdata_i`, in, APB_DATA_WIDTH: write data.
- `rsp_valid_o`, out, 1: response present.
- `rsp_ready_i`, in, 1: response consumed when high together with `rsp_valid_o`.
- `rsp_rdata_o`, out, APB_DATA_WIDTH: captured `prdata`. Reads only; 0 for writes and timeouts.
- `rsp_err_o`, out, 1: `pslverr` captured, or timeout.
- `rsp_timeout_o`, out, 1: transfer was aborted by the watchdog.
- `apb_master`, `APB_BUS.Master`: APB bus (`paddr`, `pwdata`, `pwrite`, `psel`, `penable` out; `prdata`, `pready`, `pslverr` in).

## Operation
- FSM states and transitions:
  - IDLE -> SETUP on request handshake.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> RESP on `pready`.
  - ACCESS -> RESP on timeout.
  - RESP -> IDLE on response handshake.
- `req_ready_o` = 1 only in IDLE. Address, write enable and write data are registered at the handshake.
- `paddr`, `pwrite` and `pwdata` are driven from the registers and held stable across SETUP and ACCESS.
- Bus signals by state:
  - SETUP: `psel`=1, `penable`=0.
  - ACCESS: `psel`=1, `penable`=1.
  - IDLE and RESP: `psel`=0, `penable`=0.
  - `paddr`, `pwdata` and `pwrite` keep their last value when idle.
- Completion (ACCESS with `pready`=1): capture `prdata` (read only, else 0) and `pslverr` into the response registers.
- Watchdog:
  - A counter clears on SETUP entry and increments on each ACCESS cycle without `pready`.
  - When the count reaches TIMEOUT_CYCLES, go to RESP with `rsp_err_o`=1, `rsp_timeout_o`=1, `rsp_rdata_o`=0, and drop `psel`.
  - If `pready` arrives in the same cycle the limit is reached, `pready` wins and the transfer completes normally.
- Counter width is clog2(TIMEOUT_CYCLES+1), saturating, with no wrap.
- RESP holds `rsp_*` stable until `rsp_ready_i`. No new request is accepted while a response is pending.
- Reset mid-transfer: the FSM returns to IDLE immediately. `psel`/`penable` drop asynchronously and the in-flight transfer is discarded with no response.

## Timing
- Reset values: `req_ready_o`=0 during reset, 1 in the first cycle after release (IDLE); `rsp_valid_o`=0; `rsp_rdata_o`=0; `rsp_err_o`=0; `rsp_timeout_o`=0; `psel`=0; `penable`=0; `paddr`=0; `pwdata`=0; `pwrite`=0.
- Latency: request handshake at edge 0 → SETUP in cycle 1 → ACCESS in cycle 2. With `pready` in cycle 2, `rsp_valid_o` rises in cycle 3. Minimum request-to-response is 3 cycles.
- Each `pready`=0 cycle in ACCESS adds one cycle of latency.
- Throughput is at most one transfer per 4 cycles when `rsp_ready_i` is tied high.
- All outputs are registered or decoded from state only. There are no combinational paths from `pready`, `prdata` or `pslverr` to any output.

## Structure
- `apb_master_pkg`:
  - FSM enum `apb_mst_state_e` {IDLE, SETUP, ACCESS, RESP}.
  - Timeout response data constant (0).
- Sub-module `apb_master_watchdog`: saturating counter with `clr`, `en` and `expired` ports, parameterised by TIMEOUT_CYCLES, tied off when the parameter is 0.
- Include `apb_bus.sv` for the interface definition.

## Test plan
- Write 0x1A10_1004 / 0xCAFE_0001, slave `pready`=1 immediately:
  - SETUP in cycle 1 with `psel`=1, `penable`=0, `pwrite`=1, `pwdata`=0xCAFE_0001.
  - ACCESS in cycle 2.
  - `rsp_valid_o` in cycle 3 with `rsp_err_o`=0 and `rsp_rdata_o`=0.
- Read 0x1A10_3000, slave inserts 3 wait states, then `prdata`=0x1234_5678:
  - `paddr` is stable over all ACCESS cycles.
  - `rsp_rdata_o`=0x1234_5678 arrives 6 cycles after the request handshake.
- Read with `pslverr`=1 at completion: `rsp_err_o`=1, `rsp_timeout_o`=0.
- TIMEOUT_CYCLES=8, slave never asserts `pready`:
  - `psel` drops after 8 ACCESS cycles.
  - Response shows `rsp_err_o`=1, `rsp_timeout_o`=1, `rsp_rdata_o`=0.
  - A following request completes normally.
- Response backpressure: hold `rsp_ready_i`=0 for 5 cycles.
  - `rsp_*` stay stable, `req_ready_o`=0 and `psel`=0 throughout.
  - The next request is accepted one cycle after the response handshake.
- Assert `rst_n`=0 during ACCESS: `psel` and `penable` go to 0 asynchronously, and after release `rsp_valid_o`=0 and `req_ready_o`=1.

Source files
------------

// File: rtl/apb_master_pkg.sv
// rtl/apb_master_pkg.sv - shared types and constants for the APB master bridge
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

    localparam int unsigned MAX_DATA_WIDTH = 64;

    // Read data returned when the watchdog aborts a transfer
    localparam logic [MAX_DATA_WIDTH-1:0] TIMEOUT_RDATA = '0;

endpackage

// File: rtl/apb_bus.sv
// rtl/apb_bus.sv - APB bus interface with master and slave views
interface APB_BUS #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport Master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport Slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master_watchdog.sv
// rtl/apb_master_watchdog.sv - saturating ACCESS-phase cycle counter
module apb_master_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

            logic [CW-1:0] cnt_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else if (clr) begin
                    cnt_q <= '0;
                end else if (en && (cnt_q != LIMIT)) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end

            // Fires on the stalled cycle whose increment reaches the limit
            assign expired = en && (cnt_q == LIMIT - CW'(1));
        end
    endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-outstanding APB initiator with watchdog
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic                      req_we_i,
    input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      rsp_timeout_o,
    APB_BUS.Master                    apb_master
);

    apb_mst_state_e state_q, state_d;

    logic                      init_q;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic                      we_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic [APB_DATA_WIDTH-1:0] rdata_q;
    logic                      err_q;
    logic                      tmo_q;
    logic                      psel_c;
    logic                      penable_c;
    logic                      req_hs;
    logic                      done;
    logic                      wd_expired;

    assign req_hs = req_valid_i && req_ready_o;
    assign done   = (state_q == ACCESS) && apb_master.pready;

    apb_master_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_q == SETUP),
        .en      ((state_q == ACCESS) && !apb_master.pready),
        .expired (wd_expired)
    );

    // init_q keeps req_ready_o low while reset is asserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        psel_c      = 1'b0;
        penable_c   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = init_q;
                if (req_hs) state_d = SETUP;
            end
            SETUP: begin
                psel_c  = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel_c    = 1'b1;
                penable_c = 1'b1;
                if (apb_master.pready || wd_expired) state_d = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (req_hs) begin
            addr_q  <= req_addr_i;
            we_q    <= req_we_i;
            wdata_q <= req_wdata_i;
        end
    end

    // pready has priority over a watchdog expiry in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else if (done) begin
            rdata_q <= we_q ? '0 : apb_master.prdata;
            err_q   <= apb_master.pslverr;
            tmo_q   <= 1'b0;
        end else if ((state_q == ACCESS) && wd_expired) begin
            rdata_q <= TIMEOUT_RDATA[APB_DATA_WIDTH-1:0];
            err_q   <= 1'b1;
            tmo_q   <= 1'b1;
        end
    end

    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = tmo_q;

    assign apb_master.paddr   = addr_q;
    assign apb_master.pwrite  = we_q;
    assign apb_master.pwdata  = wdata_q;
    assign apb_master.psel    = psel_c;
    assign apb_master.penable = penable_c;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    int          tests = 0;
    int          fails = 0;

    int          slv_waits = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err = 1'b0;
    int          acc_cnt = 0;

    APB_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

    apb_master_bridge #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .req_we_i      (req_we),
        .req_wdata_i   (req_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .rsp_timeout_o (rsp_timeout),
        .apb_master    (apb)
    );

    always #5 clk = ~clk;

    // Slave: raises pready after slv_waits stalled ACCESS cycles
    always @(posedge clk) acc_cnt <= (apb.psel && apb.penable && !apb.pready) ? acc_cnt + 1 : 0;
    assign apb.pready  = apb.psel && apb.penable && (acc_cnt == slv_waits);
    assign apb.prdata  = slv_rdata;
    assign apb.pslverr = apb.pready && slv_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the bridge idle; returns at a negedge after the response handshake
    task automatic xfer(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rdata, input logic err, input int bp);
        bit          tmo;
        bit          got;
        int          lat;
        int          acc;
        logic [31:0] exp_rdata;
        tmo       = (waits >= TMO);
        exp_rdata = (tmo || we) ? 32'h0 : rdata;
        slv_waits = waits;
        slv_rdata = rdata;
        slv_err   = err;
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_we    = we;
        req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_we    = ~we;
        check("setup_psel", apb.psel, 1);
        check("setup_penable", apb.penable, 0);
        check("setup_paddr", apb.paddr, addr);
        check("setup_pwrite", apb.pwrite, we);
        check("setup_pwdata", apb.pwdata, wdata);
        lat = 1;
        acc = 0;
        got = 0;
        while (!got && lat < 40) begin
            if (rsp_valid) begin
                got = 1;
            end else begin
                if (apb.psel && apb.penable) begin
                    acc++;
                    check("access_paddr", apb.paddr, addr);
                end
                @(negedge clk);
                lat++;
            end
        end
        check("rsp_arrived", got, 1);
        check("latency", lat, tmo ? 2 + TMO : 3 + waits);
        check("access_cycles", acc, tmo ? TMO : waits + 1);
        for (int i = 0; i <= bp; i++) begin
            check("rsp_valid", rsp_valid, 1);
            check("rsp_rdata", rsp_rdata, exp_rdata);
            check("rsp_err", rsp_err, tmo | err);
            check("rsp_timeout", rsp_timeout, tmo);
            check("resp_req_ready", req_ready, 0);
            check("resp_psel", apb.psel, 0);
            if (i < bp) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 0);
        check("post_req_ready", req_ready, 1);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_psel", apb.psel, 0);
        check("rst_penable", apb.penable, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("init_req_ready", req_ready, 1);
        check("init_rsp_valid", rsp_valid, 0);
        check("init_rsp_rdata", rsp_rdata, 0);
        check("init_rsp_err", rsp_err, 0);
        check("init_rsp_timeout", rsp_timeout, 0);
        check("init_paddr", apb.paddr, 0);
        check("init_pwdata", apb.pwdata, 0);
        check("init_pwrite", apb.pwrite, 0);

        // Directed cases
        xfer(32'h1A10_1004, 1'b1, 32'hCAFE_0001, 0, 32'hDEAD_BEEF, 1'b0, 0);
        xfer(32'h1A10_3000, 1'b0, 32'h0, 3, 32'h1234_5678, 1'b0, 0);
        xfer(32'h1A10_3004, 1'b0, 32'h0, 1, 32'h5555_AAAA, 1'b1, 0);
        xfer(32'h1A10_3008, 1'b0, 32'h0, 1000, 32'h7777_7777, 1'b0, 0);
        xfer(32'h1A10_300C, 1'b0, 32'h0, 2, 32'h0BAD_F00D, 1'b0, 0);
        xfer(32'h1A10_3010, 1'b0, 32'h0, TMO - 1, 32'h1357_9BDF, 1'b0, 0);
        xfer(32'h1A10_3014, 1'b0, 32'h0, TMO, 32'h2468_ACE0, 1'b0, 0);
        xfer(32'h1A10_2000, 1'b0, 32'h0, 0, 32'hFEED_FACE, 1'b0, 5);
        check("paddr_held_idle", apb.paddr, 32'h1A10_2000);

        // Randomized transfers
        for (int n = 0; n < 30; n++) begin
            xfer($urandom, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 10)),
                 $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // Reset asserted during ACCESS
        slv_waits = 1000;
        req_valid = 1'b1;
        req_addr  = 32'h1A10_4000;
        req_we    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_penable", apb.penable, 1);
        rst_n = 1'b0;
        #1;
        check("async_psel", apb.psel, 0);
        check("async_penable", apb.penable, 0);
        check("async_req_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_rsp_valid", rsp_valid, 0);
        check("post_rst_req_ready", req_ready, 1);

        xfer(32'h1A10_5000, 1'b0, 32'h0, 0, 32'hA5A5_5A5A, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=expired expected=finish");
        $fatal(1, "time limit");
    end

endmodule
